fp_mul_host: RTL
================

// Module: fp_mul_host
// PURPOSE
//  Host-side driver for the byte-serial FP multiplier link.
//  - Accepts two IEEE-754 doubles in parallel and serializes them as 16 bytes with ENABLE.
//  - Collects the 8-byte product while the multiplier asserts READY.
//  - Returns the 64-bit result over a valid/ack handshake.
//  - Sits between the system-side request logic and the multiplier core. Both blocks share CLK and RESET.
// PARAMETERS
//  GAP_CYC      2   idle cycles forced after a result is taken, before the next request (lets the core clear its counters)
//  TIMEOUT_CYC  64  max cycles in WAIT/RECV without a READY byte before abort (only with FP_HOST_TIMEOUT_EN)
// PORTS
//  CLK        in   1   clock, all logic on posedge
//  RESET      in   1   synchronous, active-high reset
//  REQ_VALID  in   1   operand request valid
//  REQ_READY  out  1   host can accept a request (high only in IDLE)
//  OPA        in   64  operand A, IEEE-754 double
//  OPB        in   64  operand B, IEEE-754 double
//  ENABLE     out  1   byte-stream valid to the multiplier
//  DATA_IN    out  8   byte stream to the multiplier
//  DATA_OUT   in   8   result byte from the multiplier
//  READY      in   1   DATA_OUT holds a valid result byte
//  RES_VALID  out  1   RES_DATA/RES_ERR valid; held until RES_ACK
//  RES_DATA   out  64  assembled product
//  RES_ERR    out  1   transaction aborted by timeout; RES_DATA is 0
//  RES_ACK    in   1   consumer takes the result
// BEHAVIOUR
//  Reset
//   - All outputs registered.
//   - On RESET: ENABLE=0, DATA_IN=0, REQ_READY=0, RES_VALID=0, RES_DATA=0, RES_ERR=0; state=GAP, counters=0.
//   - Reset mid-operation aborts at the next edge; no partial result is ever presented.
//  States: IDLE -> SEND -> WAIT -> RECV -> HOLD -> GAP -> IDLE
//   - IDLE: REQ_READY=1. On REQ_VALID & REQ_READY, latch OPA/OPB, byte_cnt=0, go to SEND.
//     REQ_READY drops on the same edge.
//   - SEND: exactly 16 consecutive cycles with ENABLE=1. The first ENABLE cycle is the cycle
//     after acceptance.
//     Byte k (0..7) = OPA[8k+7:8k], then byte 8+k = OPB[8k+7:8k], LSB byte first.
//     After byte 15: ENABLE=0, DATA_IN=0, go to WAIT.
//   - WAIT: ENABLE=0. The first cycle with READY=1 captures DATA_OUT into RES_DATA[7:0],
//     rx_cnt=1, go to RECV.
//   - RECV: each cycle with READY=1 writes DATA_OUT into RES_DATA[8*rx_cnt+:8].
//     READY low mid-burst stalls without losing bytes.
//     On the 8th byte go to HOLD; RES_VALID=1 on the following cycle.
//   - HOLD: RES_VALID and RES_DATA stable. On RES_ACK: RES_VALID=0, go to GAP.
//   - GAP: hold GAP_CYC cycles (a counter), then go to IDLE.
//  Boundary rules
//   - READY while in IDLE/SEND/HOLD/GAP is ignored.
//   - READY bytes after the 8th are ignored.
//   - REQ_VALID outside IDLE is ignored; the operands are not latched.
//   - RES_ACK outside HOLD is ignored.
//   - RES_ACK in the same cycle that RES_VALID rises is honoured: RES_VALID is high for 1 cycle.
//   - GAP_CYC=0: GAP lasts exactly 1 cycle.
//   - ENABLE is never high outside SEND. Each transaction produces exactly 16 ENABLE cycles.
//   - Latency: 1 cycle from acceptance to first ENABLE; 16 ENABLE cycles; then core latency;
//     then 8 READY cycles; then 1 cycle to RES_VALID.
// CONFIGURATION
//  FP_HOST_TIMEOUT_EN defined
//   - A watchdog counts cycles in WAIT/RECV and clears on every READY byte.
//   - When it reaches TIMEOUT_CYC: go to HOLD with RES_VALID=1, RES_ERR=1, RES_DATA=0.
//   - RES_ACK is then required as usual.
//  FP_HOST_TIMEOUT_EN undefined
//   - No watchdog; WAIT/RECV wait indefinitely.
//   - RES_ERR is tied to 0.
// TESTING (bench pairs the DUT with the FP multiplier core model, latency 3)
//  1. A=0x3FF8000000000000 (1.5), B=0x4000000000000000 (2.0)
//     -> ENABLE high exactly 16 cycles, bytes 00,00,00,00,00,00,F8,3F,00,..,00,40
//     -> RES_VALID with RES_DATA=0x4008000000000000, RES_ERR=0.
//  2. Back-to-back requests, REQ_VALID held high, RES_ACK tied 1
//     -> the second request is accepted only after GAP_CYC idle cycles;
//        both results are correct (-3.0*0.5 = 0xBFF8000000000000).
//  3. Core READY toggled 1,0,1,0 while the 8 bytes are delivered
//     -> all 8 bytes assembled in order, no duplicates.
//  4. RESET asserted on the 9th ENABLE cycle
//     -> ENABLE=0 and RES_VALID=0 from the next cycle;
//        the next request completes correctly.
//  5. RES_ACK withheld 20 cycles
//     -> RES_VALID/RES_DATA stable throughout; REQ_READY stays 0.
//  6. FP_HOST_TIMEOUT_EN defined, core never asserts READY
//     -> after TIMEOUT_CYC=64 cycles: RES_VALID=1, RES_ERR=1, RES_DATA=0.
//     Macro undefined -> RES_VALID stays 0.

Source files
------------

// File: rtl/fp_mul_host.sv
// Host-side driver for the byte-serial FP multiplier link: serialises two doubles, collects the
// 8-byte product and returns it over valid/ack. Optional watchdog: define FP_HOST_TIMEOUT_EN.
module fp_mul_host #(
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [63:0] OPA,
    input  logic [63:0] OPB,
    output logic        ENABLE,
    output logic [7:0]  DATA_IN,
    input  logic [7:0]  DATA_OUT,
    input  logic        READY,
    output logic        RES_VALID,
    output logic [63:0] RES_DATA,
    output logic        RES_ERR,
    input  logic        RES_ACK
);

`ifdef FP_HOST_TIMEOUT_EN
    localparam bit WdEnable = 1'b1;
`else
    localparam bit WdEnable = 1'b0;
`endif

    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int unsigned WdW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StRecv,
        StHold,
        StGap
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   ops_q, ops_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic [2:0]     rx_cnt_q, rx_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           req_ready_q, req_ready_d;
    logic           enable_q, enable_d;
    logic [7:0]     data_in_q, data_in_d;
    logic           res_valid_q, res_valid_d;
    logic [63:0]    res_data_q, res_data_d;
    logic           res_err_q, res_err_d;
    logic           gap_done;
    logic           wd_fire;

    // GAP_CYC of 0 or 1 both give a single GAP cycle.
    assign gap_done = (GAP_CYC <= 1) || (gap_cnt_q == GapW'(GAP_CYC - 1));
    assign wd_fire  = WdEnable && (wd_cnt_q == WdW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        ops_d       = ops_q;
        byte_cnt_d  = byte_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        req_ready_d = 1'b0;
        enable_d    = 1'b0;
        data_in_d   = 8'd0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;

        case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (REQ_VALID && req_ready_q) begin
                    ops_d       = {OPB, OPA};
                    byte_cnt_d  = 4'd0;
                    enable_d    = 1'b1;
                    data_in_d   = OPA[7:0];
                    req_ready_d = 1'b0;
                    res_err_d   = 1'b0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                // byte_cnt_q indexes the byte currently on DATA_IN
                if (byte_cnt_q == 4'd15) begin
                    wd_cnt_d = '0;
                    state_d  = StWait;
                end else begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    enable_d   = 1'b1;
                    data_in_d  = ops_q[{byte_cnt_d, 3'b000} +: 8];
                end
            end
            StWait, StRecv: begin
                if (READY) begin
                    wd_cnt_d = '0;
                    if (state_q == StWait) begin
                        res_data_d = {56'd0, DATA_OUT};
                        rx_cnt_d   = 3'd1;
                        state_d    = StRecv;
                    end else begin
                        res_data_d[{rx_cnt_q, 3'b000} +: 8] = DATA_OUT;
                        if (rx_cnt_q == 3'd7) begin
                            res_valid_d = 1'b1;
                            state_d     = StHold;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 3'd1;
                        end
                    end
                end else if (wd_fire) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    res_data_d  = '0;
                    state_d     = StHold;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            StHold: begin
                res_valid_d = 1'b1;
                if (RES_ACK) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    gap_cnt_d   = '0;
                    state_d     = StGap;
                end
            end
            StGap: begin
                if (gap_done) begin
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                gap_cnt_d = '0;
                state_d   = StGap;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StGap;
            ops_q       <= '0;
            byte_cnt_q  <= '0;
            rx_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            req_ready_q <= 1'b0;
            enable_q    <= 1'b0;
            data_in_q   <= 8'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ops_q       <= ops_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            req_ready_q <= req_ready_d;
            enable_q    <= enable_d;
            data_in_q   <= data_in_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign REQ_READY = req_ready_q;
    assign ENABLE    = enable_q;
    assign DATA_IN   = data_in_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_ERR   = res_err_q;

endmodule
